generador_temporizacion_vga: RTL and testbench

//   Single-clock VGA 640x480@60 timing generator, upstream of the memory and output-control stages.

---
 rtl/generador_temporizacion_vga_if.sv | 18 +
 rtl/generador_temporizacion_vga.sv | 126 ++++++++++++
 tb/tb_generador_temporizacion_vga.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/generador_temporizacion_vga_if.sv
// rtl/generador_temporizacion_vga_if.sv - timing bundle from the VGA timing generator to downstream stages
interface generador_temporizacion_vga_if;
  logic       pixTick;
  logic [9:0] cntHorizontal;
  logic [9:0] cntVertical;
  logic       HSync;
  logic       VSync;
  logic       blank;
  logic       frameStart;

  modport master (
    output pixTick, cntHorizontal, cntVertical, HSync, VSync, blank, frameStart
  );

  modport slave (
    input pixTick, cntHorizontal, cntVertical, HSync, VSync, blank, frameStart
  );
endinterface

// File: rtl/generador_temporizacion_vga.sv
// rtl/generador_temporizacion_vga.sv - VGA timing generator (pixel prescaler, counters, sync/blank decode; TIMING_REG_OUT_EN registers sync/blank)
module generador_temporizacion_vga #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                          Clk,
  input  logic                          Reset,
  generador_temporizacion_vga_if.master tim
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0]    V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_BEG     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Counters are 10 bits wide, so the frame geometry must fit in 1024x1024.
  if (H_TOTAL > 1024) begin : g_chk_h_total
    $error("generador_temporizacion_vga: H_TOTAL=%0d exceeds 1024", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_chk_v_total
    $error("generador_temporizacion_vga: V_TOTAL=%0d exceeds 1024", V_TOTAL);
  end
  if (CLK_DIV < 1) begin : g_chk_clk_div
    $error("generador_temporizacion_vga: CLK_DIV=%0d must be >= 1", CLK_DIV);
  end

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          fs_q, fs_d;
  logic          hs_dec, vs_dec, bl_dec;

  // Next-state: prescaler wrap, pixel tick, raster counters and frame-start flag.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_q == PRESC_LAST);
    h_d     = h_q;
    v_d     = v_q;
    fs_d    = 1'b0;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // State registers; reset clears everything so the raster restarts at (0,0).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fs_q    <= fs_d;
    end
  end

  // Sync pulses (active low) and blanking decoded straight from the counter registers.
  always_comb begin
    hs_dec = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_dec = !((v_q >= VS_BEG) && (v_q < VS_END));
    bl_dec = (h_q >= H_VIS) || (v_q >= V_VIS);
  end

`ifdef TIMING_REG_OUT_EN
  logic hs_q, vs_q, bl_q;

  // Registered sync/blank: glitch-free pins, one Clk behind the counters.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      bl_q <= 1'b1;
    end else begin
      hs_q <= hs_dec;
      vs_q <= vs_dec;
      bl_q <= bl_dec;
    end
  end

  assign tim.HSync = hs_q;
  assign tim.VSync = vs_q;
  assign tim.blank = bl_q;
`else
  assign tim.HSync = hs_dec;
  assign tim.VSync = vs_dec;
  assign tim.blank = bl_dec;
`endif

  assign tim.pixTick       = tick_q;
  assign tim.cntHorizontal = h_q;
  assign tim.cntVertical   = v_q;
  assign tim.frameStart    = fs_q;

endmodule

// File: tb/tb_generador_temporizacion_vga.sv
// tb/tb_generador_temporizacion_vga.sv - scoreboard bench: default 640x480 timing plus a reduced raster for whole-frame behaviour
module tb_generador_temporizacion_vga;

  // Instance 0: default 640x480 timing. Instance 1: small raster, CLK_DIV=3.
  localparam int P_DIV [2] = '{2, 3};
  localparam int P_HA  [2] = '{640, 16};
  localparam int P_HF  [2] = '{16, 2};
  localparam int P_HS  [2] = '{96, 4};
  localparam int P_HB  [2] = '{48, 3};
  localparam int P_VA  [2] = '{480, 8};
  localparam int P_VF  [2] = '{10, 1};
  localparam int P_VS  [2] = '{2, 2};
  localparam int P_VB  [2] = '{33, 2};

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
  } obs_t;

  logic Clk;
  logic Reset;

  generador_temporizacion_vga_if t0 ();
  generador_temporizacion_vga_if t1 ();

  generador_temporizacion_vga u_dut0 (
    .Clk   (Clk),
    .Reset (Reset),
    .tim   (t0)
  );

  generador_temporizacion_vga #(
    .CLK_DIV (3),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .tim   (t1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  obs_t q0[$];
  obs_t q1[$];

  // Reference model state
  int   m_presc [2];
  logic m_tick  [2];
  int   m_h     [2];
  int   m_v     [2];
  logic m_fs    [2];
  logic m_hs_r  [2];
  logic m_vs_r  [2];
  logic m_bl_r  [2];

  // Directed trackers
  int         cyc = 0;
  int         rel_cyc = 0;
  int         first_tick0 = -1;
  int         first_tick1 = -1;
  int         wrap0_last = -1;
  int         hs0_run = 0;
  int         vs1_run = 0;
  int         fs1_last = -1;
  int         fs1_total = 0;
  int         vmax1 = 0;
  int         hmax0 = 0;
  logic [9:0] prev_h0 = '0;
  logic       prev_hs0 = 1'b1;
  logic       prev_vs1 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic hs_of(input int id, input int h);
    return !((h >= P_HA[id] + P_HF[id]) && (h < P_HA[id] + P_HF[id] + P_HS[id]));
  endfunction

  function automatic logic vs_of(input int id, input int v);
    return !((v >= P_VA[id] + P_VF[id]) && (v < P_VA[id] + P_VF[id] + P_VS[id]));
  endfunction

  function automatic logic bl_of(input int id, input int h, input int v);
    return (h >= P_HA[id]) || (v >= P_VA[id]);
  endfunction

  task automatic model_step(input int id);
    int   op, oh, ov, ht, vt;
    logic otick;
    if (!Reset) begin
      m_presc[id] = 0; m_tick[id] = 1'b0; m_h[id] = 0; m_v[id] = 0; m_fs[id] = 1'b0;
      m_hs_r[id] = 1'b1; m_vs_r[id] = 1'b1; m_bl_r[id] = 1'b1;
      return;
    end
    ht = P_HA[id] + P_HF[id] + P_HS[id] + P_HB[id];
    vt = P_VA[id] + P_VF[id] + P_VS[id] + P_VB[id];
    op = m_presc[id]; otick = m_tick[id]; oh = m_h[id]; ov = m_v[id];
    m_tick[id]  = (op == P_DIV[id] - 1);
    m_presc[id] = (op + 1) % P_DIV[id];
    m_fs[id]    = 1'b0;
    if (otick) begin
      if (oh == ht - 1) begin
        m_h[id] = 0;
        if (ov == vt - 1) begin
          m_v[id]  = 0;
          m_fs[id] = 1'b1;
        end else begin
          m_v[id] = ov + 1;
        end
      end else begin
        m_h[id] = oh + 1;
      end
    end
    m_hs_r[id] = hs_of(id, oh);
    m_vs_r[id] = vs_of(id, ov);
    m_bl_r[id] = bl_of(id, oh, ov);
  endtask

  task automatic push_exp(input int id);
    obs_t e;
    e.tick = m_tick[id];
    e.h    = 10'(m_h[id]);
    e.v    = 10'(m_v[id]);
    e.fs   = m_fs[id];
`ifdef TIMING_REG_OUT_EN
    e.hs = m_hs_r[id];
    e.vs = m_vs_r[id];
    e.bl = m_bl_r[id];
`else
    e.hs = hs_of(id, m_h[id]);
    e.vs = vs_of(id, m_v[id]);
    e.bl = bl_of(id, m_h[id], m_v[id]);
`endif
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic pop_check(input int id);
    obs_t e, g;
    if (id == 0) begin
      e = q0.pop_front();
      g = {t0.pixTick, t0.cntHorizontal, t0.cntVertical, t0.HSync, t0.VSync, t0.blank, t0.frameStart};
    end else begin
      e = q1.pop_front();
      g = {t1.pixTick, t1.cntHorizontal, t1.cntVertical, t1.HSync, t1.VSync, t1.blank, t1.frameStart};
    end
    chk($sformatf("d%0d_pixTick@%0d", id, cyc),    32'(g.tick), 32'(e.tick));
    chk($sformatf("d%0d_cntH@%0d", id, cyc),       32'(g.h),    32'(e.h));
    chk($sformatf("d%0d_cntV@%0d", id, cyc),       32'(g.v),    32'(e.v));
    chk($sformatf("d%0d_HSync@%0d", id, cyc),      32'(g.hs),   32'(e.hs));
    chk($sformatf("d%0d_VSync@%0d", id, cyc),      32'(g.vs),   32'(e.vs));
    chk($sformatf("d%0d_blank@%0d", id, cyc),      32'(g.bl),   32'(e.bl));
    chk($sformatf("d%0d_frameStart@%0d", id, cyc), 32'(g.fs),  32'(e.fs));
  endtask

  task automatic track();
    if (!Reset) begin
      wrap0_last = -1; hs0_run = 0; vs1_run = 0; fs1_last = -1;
      prev_h0 = '0; prev_hs0 = 1'b1; prev_vs1 = 1'b1;
      return;
    end
    if (t0.pixTick === 1'b1 && first_tick0 < 0) first_tick0 = cyc - rel_cyc;
    if (t1.pixTick === 1'b1 && first_tick1 < 0) first_tick1 = cyc - rel_cyc;
    if (prev_h0 == 10'd799 && t0.cntHorizontal == 10'd0) begin
      if (wrap0_last >= 0) chk("line_period_clk", 32'(cyc - wrap0_last), 32'd1600);
      wrap0_last = cyc;
    end
    if (t0.HSync === 1'b0) hs0_run++;
    else if (prev_hs0 === 1'b0) begin
      chk("hsync_low_clk", 32'(hs0_run), 32'd192);
      hs0_run = 0;
    end
    if (t1.VSync === 1'b0) vs1_run++;
    else if (prev_vs1 === 1'b0) begin
      chk("vsync_low_clk_small", 32'(vs1_run), 32'd150);
      vs1_run = 0;
    end
    if (t1.frameStart === 1'b1) begin
      if (fs1_last >= 0) chk("frame_period_clk_small", 32'(cyc - fs1_last), 32'd975);
      fs1_last = cyc;
      fs1_total++;
    end
    if (int'(t1.cntVertical) > vmax1) vmax1 = int'(t1.cntVertical);
    if (int'(t0.cntHorizontal) > hmax0) hmax0 = int'(t0.cntHorizontal);
    prev_h0  = t0.cntHorizontal;
    prev_hs0 = t0.HSync;
    prev_vs1 = t1.VSync;
  endtask

  task automatic cycle();
    model_step(0); model_step(1);
    push_exp(0); push_exp(1);
    @(posedge Clk);
    #1;
    cyc++;
    pop_check(0); pop_check(1);
    track();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int fs_before;
    bit found;

    Reset = 1'b0;
    run(3);

    // Release and run the default raster for three lines, the small raster for several frames
    Reset = 1'b1;
    rel_cyc = cyc;
    run(5000);
    chk("first_tick_div2", 32'(first_tick0), 32'd2);
    chk("first_tick_div3", 32'(first_tick1), 32'd3);
    chk("hmax_default", 32'(hmax0), 32'd799);
    chk("vmax_small", 32'(vmax1), 32'd12);

    // Wait for h=9, v=5 on the small raster, then reset mid-frame
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (t1.cntHorizontal == 10'd9 && t1.cntVertical == 10'd5) found = 1'b1;
      else cycle();
    end
    chk("wait_mid_frame", 32'(found), 32'd1);
    Reset = 1'b0;
    #1;
    model_step(0); model_step(1);
    push_exp(0); push_exp(1);
    pop_check(0); pop_check(1);
    track();
    run(3);

    Reset = 1'b1;
    rel_cyc = cyc;
    fs_before = fs1_total;
    run(900);
    chk("no_stray_frameStart", 32'(fs1_total - fs_before), 32'd0);
    run(400);
    chk("frameStart_after_restart", 32'(fs1_total - fs_before), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
